// File: rtl/multi_edge_detector.sv
// N-channel edge detector: one Moore FSM per input bit, global detect mode, saturating edge counter.
// Define SYNC_STAGE_EN to put a two-flop synchronizer in front of every input bit.
module multi_edge_detector #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    I,
    input  logic [1:0]      mode,
    input  logic            count_clr,
    output logic [N-1:0]    Y,
    output logic            any_edge,
    output logic [CW-1:0]   edge_count,
    output logic [3*N-1:0]  present_state
);
    typedef enum logic [2:0] {
        INIT = 3'b000,
        ZERO = 3'b001,
        ONE  = 3'b010,
        RISE = 3'b011,
        FALL = 3'b100
    } state_e;

    // Extra headroom so count + popcount never overflows before the saturation test.
    localparam int SW = CW + 5;
    localparam logic [SW-1:0] CNT_MAX = {5'b00000, {CW{1'b1}}};

    function automatic logic [4:0] popcount(input logic [N-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k < N; k++) begin
            c = c + {4'b0000, v[k]};
        end
        return c;
    endfunction

    logic [N-1:0]  i_s;
    state_e        state_q [N];
    state_e        state_d [N];
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [N-1:0]  y_s;
    logic [SW-1:0] sum_s;

`ifdef SYNC_STAGE_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync1_d;
    logic [N-1:0] sync2_q;
    logic [N-1:0] sync2_d;

    // Synchronizer next-state: shift the raw input through two stages.
    always_comb begin
        sync1_d = I;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared to 0 on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {N{1'b0}};
            sync2_q <= {N{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign i_s = sync2_q;
`else
    assign i_s = I;
`endif

    // Per-channel next state; INIT resolves the level without reporting an edge.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            state_d[k] = INIT;
            case (state_q[k])
                INIT:    state_d[k] = i_s[k] ? ONE  : ZERO;
                ZERO:    state_d[k] = i_s[k] ? RISE : ZERO;
                ONE:     state_d[k] = i_s[k] ? ONE  : FALL;
                RISE:    state_d[k] = i_s[k] ? ONE  : FALL;
                FALL:    state_d[k] = i_s[k] ? RISE : ZERO;
                default: state_d[k] = INIT;
            endcase
        end
    end

    // Mode is sampled every edge; the FSMs keep tracking levels whatever the mode.
    always_comb begin
        mode_d = mode;
    end

    // Pulse decode from the registered state and registered mode only.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            y_s[k] = 1'b0;
            case (state_q[k])
                RISE:    y_s[k] = (mode_q == 2'b00) || (mode_q == 2'b10);
                FALL:    y_s[k] = (mode_q == 2'b01) || (mode_q == 2'b10);
                default: y_s[k] = 1'b0;
            endcase
        end
    end

    // Saturating accumulate of the current pulse vector; clear wins over increment.
    always_comb begin
        sum_s = SW'(count_q) + SW'(popcount(y_s));
        if (count_clr) begin
            count_d = {CW{1'b0}};
        end else if (sum_s > CNT_MAX) begin
            count_d = {CW{1'b1}};
        end else begin
            count_d = sum_s[CW-1:0];
        end
    end

    // State, mode and counter registers; reset parks mode at disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= INIT;
            end
            mode_q  <= 2'b11;
            count_q <= {CW{1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= state_d[k];
            end
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    // Flatten per-channel state onto the debug port, channel k at [3k+2:3k].
    always_comb begin
        present_state = {(3*N){1'b0}};
        for (int k = 0; k < N; k++) begin
            present_state[3*k +: 3] = state_q[k];
        end
    end

    assign Y          = y_s;
    assign any_edge   = |y_s;
    assign edge_count = count_q;

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter N, default 4, number of independent input channels (1..16).
REQ-002 The block SHALL have parameter CW, default 8, width of the edge event counter (2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port I, input, N, the per-channel level inputs.
REQ-006 The block SHALL have port mode, input, 2, the global detect mode: 00 rise, 01 fall, 10 both, 11 disabled.
REQ-007 The block SHALL have port count_clr, input, 1, a synchronous clear of edge_count.
REQ-008 The block SHALL have port Y, output, N, per-channel one-cycle edge pulses.
REQ-009 The block SHALL have port any_edge, output, 1, the OR of all Y bits.
REQ-010 The block SHALL have port edge_count, output, CW, the saturating total of asserted pulses.
REQ-011 The block SHALL have port present_state, output, 3*N, per-channel FSM state; channel k occupies bits [3k+2:3k].

Function
REQ-012 Each channel SHALL run an independent Moore FSM with encodings INIT=000, ZERO=001, ONE=010, RISE=011, FALL=100.
REQ-013 INIT SHALL transition to ONE if the sampled I=1 and to ZERO if it is 0, with no pulse, so no spurious edge is reported after reset.
REQ-014 ZERO SHALL transition to RISE on I=1 and stay in ZERO on I=0.
REQ-015 ONE SHALL transition to FALL on I=0 and stay in ONE on I=1.
REQ-016 RISE SHALL transition to ONE on I=1 and to FALL on I=0; FALL SHALL transition to ZERO on I=0 and to RISE on I=1.
REQ-017 Unused encodings 101-111 SHALL transition to INIT on the next edge.
REQ-018 mode SHALL be registered on every clk edge; Y[k] SHALL be decoded from channel k's state and the registered mode.
REQ-019 Y[k] SHALL be 1 when state=RISE and registered mode is 00 or 10.
REQ-020 Y[k] SHALL be 1 when state=FALL and registered mode is 01 or 10.
REQ-021 Y[k] SHALL be 0 in all other cases, including mode 11.
REQ-022 Latency SHALL be 1 cycle: an edge sampled at clock edge t gives Y high for the cycle between edges t and t+1.
REQ-023 Alternating input toggles every cycle SHALL give a pulse every cycle in mode 10, and every other cycle in modes 00 and 01.
REQ-024 The FSM SHALL track the input level regardless of mode, so a mode change takes effect from the next clk edge without losing level history.
REQ-025 On each clk edge, edge_count SHALL add the popcount of the current Y vector.
REQ-026 edge_count SHALL saturate at 2^CW-1 and never wrap; an addition that would exceed the maximum SHALL load 2^CW-1.
REQ-027 When count_clr=1, edge_count SHALL load 0 on that edge, and clear SHALL take priority over any simultaneous increment.

Reset
REQ-028 While reset=1, every channel state SHALL be INIT, the registered mode SHALL be 11, and Y, any_edge and edge_count SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-pulse SHALL drop Y to 0 immediately, with no partial count retained.
REQ-030 After reset deasserts, the first clk edge SHALL only resolve INIT, and the earliest possible pulse SHALL follow the second edge.

Configuration
REQ-031 When SYNC_STAGE_EN is defined, each I bit SHALL pass through a two-flop synchronizer (reset to 0) before the FSM, adding 2 cycles of latency, so total latency is 3 cycles.
REQ-032 When SYNC_STAGE_EN is not defined, I SHALL feed the FSM directly, and the bench SHALL drive I away from clk edges.

Verification
REQ-033 Scenario: reset held 10 ns, I=4'b1111 throughout -> states INIT then ONE, Y never asserted, edge_count=0.
REQ-034 Scenario: mode=01, channel 0 pattern 1,0,1,1,0 on consecutive edges -> Y[0] high exactly twice, each one cycle after the 1->0 sample; edge_count=2.
REQ-035 Scenario: mode=10, I[3:0] toggling 0000/1111 every cycle for 8 cycles -> Y=4'b1111 each cycle after the first transition; edge_count increments by 4 per cycle.
REQ-036 Scenario: CW=4, sustained edges pushing the count past 15 -> edge_count holds 15. Then count_clr=1 on a cycle with Y=4'b0011 -> edge_count=0 on that edge.
REQ-037 Scenario: mode switches from 00 to 11 while channel 1 is in RISE -> Y[1]=0 from the next edge. Then mode=00 with I[1] already high -> no pulse until the next 0->1.
REQ-038 Scenario: reset asserted asynchronously mid-cycle while Y=4'b0101 -> Y, edge_count and present_state go to 0/INIT before the next clk edge.
